// File: rtl/tblink_rpc_pkg.sv
// Shared types for the tblink RPC command initiator: FSM state encoding and
// packet header layout.
package tblink_rpc_pkg;

    typedef enum logic [3:0] {
        CO_IDLE,
        CO_TX_DST,
        CO_TX_SZ,
        CO_TX_CMD,
        CO_TX_PARAM,
        CO_RX_ADR,
        CO_RX_SZ,
        CO_RX_DATA,
        CO_DONE
    } cmdout_state_e;

    // Byte offsets of the fixed header fields within a request packet
    localparam logic [1:0] HDR_ADDR = 2'd0;
    localparam logic [1:0] HDR_SZ   = 2'd1;
    localparam logic [1:0] HDR_CMD  = 2'd2;

    function automatic logic [7:0] hdr_byte(
        input logic [1:0] off,
        input logic [7:0] addr,
        input logic [7:0] sz,
        input logic [7:0] cmd
    );
        logic [7:0] b;
        case (off)
            HDR_ADDR: b = addr;
            HDR_SZ:   b = sz;
            HDR_CMD:  b = cmd;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tblink_rpc_cmdout.sv
// Outbound command initiator: serializes one latched command as a request
// packet on tx, then parses the response packet on rx and hands it back.
module tblink_rpc_cmdout
    import tblink_rpc_pkg::*;
#(
    parameter int DST_ADDR      = 1,
    parameter int CMD_PARAMS_SZ = 4,
    parameter int CMD_RSP_SZ    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 cmd_out,
    input  logic [7:0]                 cmd_out_sz,
    input  logic [8*CMD_PARAMS_SZ-1:0] cmd_out_params,
    input  logic                       cmd_out_put_i,
    output logic                       cmd_out_get_i,
    output logic [8*CMD_RSP_SZ-1:0]    cmd_out_rsp,
    output logic [7:0]                 cmd_out_rsp_sz,
    output logic [7:0]                 tx_dat,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic [7:0]                 rx_dat,
    input  logic                       rx_valid,
    output logic                       rx_ready
);

    localparam int         PIDX_W   = (CMD_PARAMS_SZ > 1) ? $clog2(CMD_PARAMS_SZ) : 1;
    localparam logic [7:0] PS_BYTES = 8'(CMD_PARAMS_SZ);
    localparam logic [7:0] DST_BYTE = 8'(DST_ADDR);

    cmdout_state_e               state_q, state_d;
    logic [7:0]                  cmd_q, cmd_d;
    logic [7:0]                  n_q, n_d;
    logic [8*CMD_PARAMS_SZ-1:0]  params_q, params_d;
    logic [7:0]                  idx_q, idx_d;
    logic [7:0]                  m_q, m_d;
    logic [8*CMD_RSP_SZ-1:0]     rsp_q, rsp_d;
    logic [7:0]                  rsp_sz_q, rsp_sz_d;
    logic                        get_q, get_d;

    logic                        tx_fire;
    logic                        rx_fire;
    logic                        pending;
    logic [PIDX_W-1:0]           pidx;
    logic [7:0]                  param_byte;

    assign tx_valid = (state_q == CO_TX_DST) || (state_q == CO_TX_SZ) ||
                      (state_q == CO_TX_CMD) || (state_q == CO_TX_PARAM);
    assign rx_ready = (state_q == CO_RX_ADR) || (state_q == CO_RX_SZ) ||
                      (state_q == CO_RX_DATA);

    assign tx_fire = tx_valid && tx_ready;
    assign rx_fire = rx_valid && rx_ready;
    assign pending = (cmd_out_put_i != get_q);

    // Param index never reaches n_q, and n_q <= CMD_PARAMS_SZ, so the narrowed index is exact
    assign pidx       = idx_q[PIDX_W-1:0];
    assign param_byte = params_q[{pidx, 3'b000} +: 8];

    always_comb begin
        tx_dat = 8'h00;
        case (state_q)
            CO_TX_DST:   tx_dat = hdr_byte(HDR_ADDR, DST_BYTE, n_q + 8'd1, cmd_q);
            CO_TX_SZ:    tx_dat = hdr_byte(HDR_SZ,   DST_BYTE, n_q + 8'd1, cmd_q);
            CO_TX_CMD:   tx_dat = hdr_byte(HDR_CMD,  DST_BYTE, n_q + 8'd1, cmd_q);
            CO_TX_PARAM: tx_dat = param_byte;
            default:     tx_dat = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        n_d      = n_q;
        params_d = params_q;
        idx_d    = idx_q;
        m_d      = m_q;
        rsp_d    = rsp_q;
        rsp_sz_d = rsp_sz_q;
        get_d    = get_q;

        case (state_q)
            CO_IDLE: begin
                if (pending) begin
                    cmd_d    = cmd_out;
                    n_d      = (cmd_out_sz > PS_BYTES) ? PS_BYTES : cmd_out_sz;
                    params_d = cmd_out_params;
                    idx_d    = 8'd0;
                    state_d  = CO_TX_DST;
                end
            end
            CO_TX_DST: begin
                if (tx_fire) state_d = CO_TX_SZ;
            end
            CO_TX_SZ: begin
                if (tx_fire) state_d = CO_TX_CMD;
            end
            CO_TX_CMD: begin
                if (tx_fire) begin
                    idx_d   = 8'd0;
                    state_d = (n_q == 8'd0) ? CO_RX_ADR : CO_TX_PARAM;
                end
            end
            CO_TX_PARAM: begin
                if (tx_fire) begin
                    if (idx_q == n_q - 8'd1) begin
                        state_d = CO_RX_ADR;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            CO_RX_ADR: begin
                if (rx_fire) state_d = CO_RX_SZ;
            end
            CO_RX_SZ: begin
                if (rx_fire) begin
                    m_d      = rx_dat;
                    rsp_sz_d = rx_dat;
                    rsp_d    = '0;
                    idx_d    = 8'd0;
                    state_d  = (rx_dat == 8'd0) ? CO_DONE : CO_RX_DATA;
                end
            end
            CO_RX_DATA: begin
                if (rx_fire) begin
                    // Bytes past the capture window are still consumed, just not stored
                    for (int k = 0; k < CMD_RSP_SZ; k++) begin
                        if (idx_q == 8'(k)) rsp_d[8*k +: 8] = rx_dat;
                    end
                    if (idx_q == m_q - 8'd1) begin
                        state_d = CO_DONE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            CO_DONE: begin
                get_d   = ~get_q;
                state_d = CO_IDLE;
            end
            default: state_d = CO_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= CO_IDLE;
            cmd_q    <= 8'h00;
            n_q      <= 8'h00;
            params_q <= '0;
            idx_q    <= 8'h00;
            m_q      <= 8'h00;
            rsp_q    <= '0;
            rsp_sz_q <= 8'h00;
            get_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            n_q      <= n_d;
            params_q <= params_d;
            idx_q    <= idx_d;
            m_q      <= m_d;
            rsp_q    <= rsp_d;
            rsp_sz_q <= rsp_sz_d;
            get_q    <= get_d;
        end
    end

    assign cmd_out_get_i  = get_q;
    assign cmd_out_rsp    = rsp_q;
    assign cmd_out_rsp_sz = rsp_sz_q;

endmodule

// File: tb/tb_tblink_rpc_cmdout.sv
// Self-checking bench for tblink_rpc_cmdout: table vectors, reset/abort
// sequence, and randomized traffic against a packet-level reference model.
module tb_tblink_rpc_cmdout;

    localparam int DST = 1;
    localparam int PS  = 4;
    localparam int RS  = 1;

    logic              clock;
    logic              reset;
    logic [7:0]        cmd_out;
    logic [7:0]        cmd_out_sz;
    logic [8*PS-1:0]   cmd_out_params;
    logic              cmd_out_put_i;
    logic              cmd_out_get_i;
    logic [8*RS-1:0]   cmd_out_rsp;
    logic [7:0]        cmd_out_rsp_sz;
    logic [7:0]        tx_dat;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_dat;
    logic              rx_valid;
    logic              rx_ready;

    tblink_rpc_cmdout #(
        .DST_ADDR      (DST),
        .CMD_PARAMS_SZ (PS),
        .CMD_RSP_SZ    (RS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_out        (cmd_out),
        .cmd_out_sz     (cmd_out_sz),
        .cmd_out_params (cmd_out_params),
        .cmd_out_put_i  (cmd_out_put_i),
        .cmd_out_get_i  (cmd_out_get_i),
        .cmd_out_rsp    (cmd_out_rsp),
        .cmd_out_rsp_sz (cmd_out_rsp_sz),
        .tx_dat         (tx_dat),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_dat         (rx_dat),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pay [0:7];

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  sz;
        logic [31:0] prm;
        int          m;
        logic [7:0]  p0, p1, p2;
        int          stall;
        int          exp_len;
        logic [7:0]  exp_rsp;
        logic [7:0]  exp_rsp_sz;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One requester transaction plus tx sink / rx source.  abort_rx >= 0 returns
    // early once that many response bytes have been consumed (no checks).
    task automatic run_txn(input string nm, input logic [7:0] cmd, input logic [7:0] sz,
                           input logic [31:0] prm, input int m, input int stall_idx,
                           input int abort_rx, input bit rnd, input int exp_len,
                           input logic [7:0] exp_rsp, input logic [7:0] exp_rsp_sz);
        logic [7:0] expq[$];
        logic [7:0] got[$];
        logic [7:0] rxq[$];
        int         n;
        int         rx_idx;
        int         toggles;
        int         stall_cnt;
        int         early;
        int         stab_err;
        bit         finished;
        bit         stalled;
        bit         ready;
        bit         rv;
        logic       prev_get;
        logic [7:0] held;

        n = (sz > 8'(PS)) ? PS : int'(sz);
        expq.push_back(8'(DST));
        expq.push_back(8'(n + 1));
        expq.push_back(cmd);
        for (int i = 0; i < n; i++) expq.push_back(prm[8*i +: 8]);
        rxq.push_back(8'h01);
        rxq.push_back(8'(m));
        for (int i = 0; i < m; i++) rxq.push_back(pay[i]);

        @(negedge clock);
        cmd_out        = cmd;
        cmd_out_sz     = sz;
        cmd_out_params = prm;
        cmd_out_put_i  = ~cmd_out_put_i;
        prev_get  = cmd_out_get_i;
        toggles   = 0;
        rx_idx    = 0;
        stall_cnt = 0;
        early     = 0;
        stab_err  = 0;
        finished  = 0;
        stalled   = 0;
        held      = 8'h00;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            // Inputs were latched at the previous edge; scrambling them must not matter
            cmd_out        = 8'($urandom);
            cmd_out_sz     = 8'($urandom);
            cmd_out_params = $urandom;
            if (cmd_out_get_i !== prev_get) toggles++;
            prev_get = cmd_out_get_i;
            if (toggles > 0 && cmd_out_get_i == cmd_out_put_i) begin
                finished = 1;
                break;
            end
            if (abort_rx >= 0 && rx_idx >= abort_rx) begin
                tx_ready = 1'b0;
                rx_valid = 1'b0;
                return;
            end
            if (stalled && (tx_valid !== 1'b1 || tx_dat !== held)) stab_err++;
            if (tx_valid && got.size() == stall_idx && stall_cnt < 5) begin
                ready = 0;
                stall_cnt++;
            end else begin
                ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (tx_valid && ready) got.push_back(tx_dat);
            stalled  = tx_valid && !ready;
            held     = tx_dat;
            tx_ready = ready;
            if (rx_idx < rxq.size()) begin
                rv       = rnd ? ($urandom_range(2) != 0) : 1'b1;
                rx_valid = rv;
                rx_dat   = rxq[rx_idx];
                if (rv && rx_ready) begin
                    if (got.size() < expq.size()) early++;
                    rx_idx++;
                end
            end else begin
                rx_valid = 1'b0;
            end
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;

        check({nm, " completed"}, 32'(finished), 32'd1);
        check({nm, " tx_len"}, got.size(), exp_len);
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            check($sformatf("%s tx_byte%0d", nm, i), got[i], expq[i]);
        check({nm, " rx_consumed"}, rx_idx, m + 2);
        check({nm, " rx_during_tx"}, early, 0);
        check({nm, " get_toggles"}, toggles, 1);
        check({nm, " rsp"}, cmd_out_rsp, exp_rsp);
        check({nm, " rsp_sz"}, cmd_out_rsp_sz, exp_rsp_sz);
        if (stall_idx >= 0) begin
            check({nm, " stall_cycles"}, stall_cnt, 5);
            check({nm, " stall_stable"}, stab_err, 0);
        end
        $display("txn %s: cmd=%02h sz=%0d m=%0d tx_bytes=%0d rsp=%02h rsp_sz=%0d",
                 nm, cmd, sz, m, got.size(), cmd_out_rsp, cmd_out_rsp_sz);
    endtask

    task automatic run_vec(input string nm, input int i);
        pay[0] = vecs[i].p0;
        pay[1] = vecs[i].p1;
        pay[2] = vecs[i].p2;
        run_txn(nm, vecs[i].cmd, vecs[i].sz, vecs[i].prm, vecs[i].m, vecs[i].stall, -1, 1'b0,
                vecs[i].exp_len, vecs[i].exp_rsp, vecs[i].exp_rsp_sz);
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'd2, 32'h0000BBAA, 1, 8'h3C, 8'h00, 8'h00, -1, 5, 8'h3C, 8'd1};
        vecs[1] = '{8'h10, 8'd0, 32'h12345678, 0, 8'h00, 8'h00, 8'h00, -1, 3, 8'h00, 8'd0};
        vecs[2] = '{8'h22, 8'd9, 32'h44332211, 3, 8'h11, 8'h22, 8'h33, -1, 7, 8'h11, 8'd3};
        vecs[3] = '{8'h07, 8'd4, 32'hDDCCBBAA, 2, 8'h5A, 8'hA5, 8'h00,  4, 7, 8'h5A, 8'd2};

        reset          = 1'b1;
        cmd_out        = 8'h00;
        cmd_out_sz     = 8'h00;
        cmd_out_params = '0;
        cmd_out_put_i  = 1'b0;
        tx_ready       = 1'b0;
        rx_dat         = 8'h00;
        rx_valid       = 1'b0;
        repeat (3) @(negedge clock);
        check("reset tx_valid", tx_valid, 0);
        check("reset tx_dat", tx_dat, 0);
        check("reset rx_ready", rx_ready, 0);
        check("reset get", cmd_out_get_i, 0);
        check("reset rsp", cmd_out_rsp, 0);
        check("reset rsp_sz", cmd_out_rsp_sz, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Rows 0/1 back-to-back: second put issued as soon as get matches
        run_vec("v1_basic", 0);
        run_vec("v2_nosz", 1);
        run_vec("v3_clamp", 2);
        run_vec("v4_stall", 3);

        // Reset in RX_DATA after addr, size and two of three payload bytes
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_txn("v5_abort", 8'h33, 8'd1, 32'h000000EE, 3, -1, 4, 1'b0, 4, 8'h11, 8'd3);
        reset         = 1'b1;
        cmd_out_put_i = 1'b0;
        #1;
        check("midreset tx_valid", tx_valid, 0);
        check("midreset rx_ready", rx_ready, 0);
        check("midreset get", cmd_out_get_i, 0);
        check("midreset rsp_sz", cmd_out_rsp_sz, 0);
        check("midreset rsp", cmd_out_rsp, 0);
        $display("txn v5_abort: reset applied mid-response");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_vec("v5_after", 0);

        for (int t = 0; t < 25; t++) begin
            logic [7:0]  c, s;
            logic [31:0] p;
            int          m, nn;
            c  = 8'($urandom);
            s  = 8'($urandom_range(9));
            p  = $urandom;
            m  = $urandom_range(5);
            for (int k = 0; k < 8; k++) pay[k] = 8'($urandom);
            nn = (int'(s) > PS) ? PS : int'(s);
            run_txn($sformatf("rnd%0d", t), c, s, p, m, -1, -1, 1'b1, nn + 3,
                    (m > 0) ? pay[0] : 8'h00, 8'(m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
